// File: rtl/sap_pkg.sv
// Shared SAP constants and the program-loader state type; the SRAM and MAR
// size themselves from the same DEPTH/ADDR_W/DATA_W values.
package sap_pkg;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/sap_prog_loader_if.sv
// Byte-stream input and SRAM write-port bundle of the program loader.
// The slave modport is the loader; the master side is the image source/SRAM.
interface sap_prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/sap_prog_loader.sv
// Loads a 16-byte program image plus checksum byte into the SAP program SRAM,
// holding the CPU in reset until the image sum verifies as zero mod 256.
module sap_prog_loader #(
    parameter int DEPTH  = sap_pkg::DEPTH,
    parameter int ADDR_W = sap_pkg::ADDR_W,
    parameter int DATA_W = sap_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    sap_prog_loader_if.slave    bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   checksum
);

    import sap_pkg::*;

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;

    logic              inReady;
    logic              accept;
    logic [DATA_W-1:0] sumNext;

    // in_ready depends on state alone so upstream sees no path from in_valid.
    assign inReady = (state_q == LOAD) || (state_q == SUM);
    assign accept  = inReady && bus.in_valid;
    assign sumNext = checksum_q + bus.in_data;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        memWe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;

        case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    state_d    = LOAD;
                    count_d    = '0;
                    checksum_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    memWe_d    = 1'b1;
                    memAddr_d  = count_q;
                    memWdata_d = bus.in_data;
                    checksum_d = sumNext;
                    if (count_q == ADDR_W'(DEPTH - 1)) begin
                        count_d = '0;
                        state_d = SUM;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            SUM: begin
                // The checksum byte only closes the sum; it is never written.
                if (accept) begin
                    checksum_d = sumNext;
                    state_d    = (sumNext == '0) ? DONE : ERR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            checksum_q <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    // The CPU stays in reset from the first LOAD cycle until DONE has passed.
    assign cpu_hold      = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = (state_q == ERR);
    assign checksum      = checksum_q;
    assign bus.in_ready  = inReady;
    assign bus.mem_we    = memWe_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;

endmodule

// File: tb/tb_sap_prog_loader.sv
// Directed bench for sap_prog_loader: a byte-count model predicts every output
// each cycle, and literal checks pin the checksum, done/hold timing and SRAM image.
module tb_sap_prog_loader;

    import sap_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] checksum;

    sap_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sap_prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEnable = 1'b0;

    logic [7:0] img [16] = '{8'h09, 8'h1A, 8'h1B, 8'h2B, 8'hE0, 8'hF0, 8'hFF, 8'hFF,
                             8'hFF, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks how many bytes of the current image were taken
    // and their running sum; the 17th byte decides between done and error.
    bit         mLoading = 1'b0;
    int         mTaken   = 0;
    logic [7:0] mSum     = 8'h00;
    bit         mDone    = 1'b0;
    bit         mErr     = 1'b0;
    bit         mWe      = 1'b0;
    logic [3:0] mAddr    = 4'h0;
    logic [7:0] mWdata   = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mLoading <= 1'b0;
            mTaken   <= 0;
            mSum     <= 8'h00;
            mDone    <= 1'b0;
            mErr     <= 1'b0;
            mWe      <= 1'b0;
            mAddr    <= 4'h0;
            mWdata   <= 8'h00;
        end else begin
            automatic bit         acc     = mLoading && bus.in_valid;
            automatic bit         loading = mLoading;
            automatic int         taken   = mTaken;
            automatic logic [7:0] sum     = mSum;
            automatic bit         e       = mErr;
            automatic bit         dn      = 1'b0;
            mWe <= acc && (mTaken < DEPTH);
            if (acc && (mTaken < DEPTH)) begin
                mAddr  <= 4'(mTaken);
                mWdata <= bus.in_data;
            end
            if (acc) begin
                sum   = sum + bus.in_data;
                taken = taken + 1;
                if (taken == DEPTH + 1) begin
                    loading = 1'b0;
                    if (sum == 8'h00) dn = 1'b1;
                    else              e  = 1'b1;
                end
            end
            if (start && !mLoading && !mDone) begin
                loading = 1'b1;
                taken   = 0;
                sum     = 8'h00;
                e       = 1'b0;
            end
            mLoading <= loading;
            mTaken   <= taken;
            mSum     <= sum;
            mErr     <= e;
            mDone    <= dn;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    int doneCount = 0;
    always @(negedge clk) begin
        if (!rst && checkEnable) begin
            checkOutput("in_ready", 32'(bus.in_ready), 32'(mLoading));
            checkOutput("cpu_hold", 32'(cpu_hold), 32'(mLoading || mDone || mErr));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("err", 32'(err), 32'(mErr));
            checkOutput("checksum", 32'(checksum), 32'(mSum));
            checkOutput("mem_we", 32'(bus.mem_we), 32'(mWe));
            if (mWe) begin
                checkOutput("mem_addr", 32'(bus.mem_addr), 32'(mAddr));
                checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(mWdata));
            end
            if (done === 1'b1) doneCount++;
        end
    end

    // SRAM stand-in capturing what the loader writes.
    logic [7:0] sram [16];
    int         writeCount = 0;
    bit         sawAA      = 1'b0;
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            sram[bus.mem_addr] <= bus.mem_wdata;
            writeCount         <= writeCount + 1;
            if (bus.mem_wdata == 8'hAA) sawAA <= 1'b1;
        end
    end

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit withStart);
        bit accepted = 1'b0;
        bit rdy;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (withStart) start = 1'b1;
        for (int c = 0; c < 20 && !accepted; c++) begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            accepted = rdy;
        end
        start = 1'b0;
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: byte %0h not taken, required within 20 cycles", b);
        end
    endtask

    // Sends the image (first stopAfter bytes of 17), optionally with an idle
    // cycle before each byte and a stray start pulse alongside byte 5.
    task automatic applyStimulus(input logic [7:0] finalByte, input bit toggle,
                                 input bit pokeStart, input int stopAfter);
        for (int i = 0; i < 17 && i < stopAfter; i++) begin
            if (toggle) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'h55;
                @(posedge clk); #1;
            end
            sendByte((i < 16) ? img[i] : finalByte, pokeStart && (i == 5));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    int wcStart;
    int dcStart;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("reset_mem_we", 32'(bus.mem_we), 32'h0);
        checkOutput("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
        checkOutput("reset_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        checkOutput("reset_cpu_hold", 32'(cpu_hold), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        checkOutput("reset_checksum", 32'(checksum), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkEnable = 1'b1;

        // AA offered in IDLE must never be consumed.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        idleCycles(3);
        bus.in_valid = 1'b0;

        $display("[TB] nominal load");
        wcStart = writeCount;
        dcStart = doneCount;
        pulseStart();
        applyStimulus(8'hC8, 1'b0, 1'b0, 17);
        checkOutput("nominal_done_pulse", 32'(done), 32'h1);
        checkOutput("nominal_hold_at_done", 32'(cpu_hold), 32'h1);
        checkOutput("nominal_checksum", 32'(checksum), 32'h00);
        idleCycles(1);
        checkOutput("nominal_hold_released", 32'(cpu_hold), 32'h0);
        checkOutput("nominal_done_cleared", 32'(done), 32'h0);
        idleCycles(1);
        checkOutput("nominal_writes", 32'(writeCount - wcStart), 32'd16);
        checkOutput("nominal_done_count", 32'(doneCount - dcStart), 32'd1);
        checkOutput("nominal_sram0", 32'(sram[0]), 32'h09);
        checkOutput("nominal_sram4", 32'(sram[4]), 32'hE0);
        checkOutput("nominal_sram11", 32'(sram[11]), 32'h03);
        checkOutput("nominal_sram15", 32'(sram[15]), 32'hFF);
        checkOutput("idle_AA_not_written", 32'(sawAA), 32'h0);

        $display("[TB] bad checksum then reload");
        dcStart = doneCount;
        pulseStart();
        applyStimulus(8'hC9, 1'b0, 1'b0, 17);
        checkOutput("bad_err", 32'(err), 32'h1);
        checkOutput("bad_checksum", 32'(checksum), 32'h01);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        idleCycles(3);
        bus.in_valid = 1'b0;
        checkOutput("bad_err_sticky", 32'(err), 32'h1);
        checkOutput("bad_hold", 32'(cpu_hold), 32'h1);
        checkOutput("bad_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("bad_no_done", 32'(doneCount - dcStart), 32'd0);
        pulseStart();
        checkOutput("restart_err_cleared", 32'(err), 32'h0);
        applyStimulus(8'hC8, 1'b0, 1'b0, 17);
        checkOutput("restart_done", 32'(done), 32'h1);
        idleCycles(2);

        $display("[TB] backpressure gaps with stray start at byte 5");
        wcStart = writeCount;
        dcStart = doneCount;
        pulseStart();
        applyStimulus(8'hC8, 1'b1, 1'b1, 17);
        checkOutput("gap_done", 32'(done), 32'h1);
        checkOutput("gap_checksum", 32'(checksum), 32'h00);
        idleCycles(2);
        checkOutput("gap_writes", 32'(writeCount - wcStart), 32'd16);
        checkOutput("gap_done_count", 32'(doneCount - dcStart), 32'd1);
        checkOutput("gap_sram5", 32'(sram[5]), 32'hF0);

        $display("[TB] reset mid-load");
        pulseStart();
        applyStimulus(8'hC8, 1'b0, 1'b0, 7);
        rst = 1'b1;
        #2;
        checkOutput("midrst_cpu_hold", 32'(cpu_hold), 32'h0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("midrst_mem_we", 32'(bus.mem_we), 32'h0);
        checkOutput("midrst_mem_addr", 32'(bus.mem_addr), 32'h0);
        checkOutput("midrst_checksum", 32'(checksum), 32'h0);
        checkOutput("midrst_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        wcStart = writeCount;
        pulseStart();
        applyStimulus(8'hC8, 1'b0, 1'b0, 17);
        checkOutput("reload_done", 32'(done), 32'h1);
        idleCycles(2);
        checkOutput("reload_writes", 32'(writeCount - wcStart), 32'd16);
        checkOutput("reload_hold", 32'(cpu_hold), 32'h0);
        checkOutput("final_AA_not_written", 32'(sawAA), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
